// File: rtl/j11sram_pkg.sv
// Shared definitions for the J11 async-SRAM controller: FSM state codes,
// wait-counter width and the per-byte even-parity helper.
package j11sram_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_WSETUP = 3'd2;
  localparam logic [2:0] ST_WPULSE = 3'd3;
  localparam logic [2:0] ST_WHOLD  = 3'd4;
  localparam logic [2:0] ST_ACK    = 3'd5;

  // bit 0 covers the low byte, bit 1 the high byte
  function automatic logic [1:0] byte_par(input logic [15:0] d);
    return {^d[15:8], ^d[7:0]};
  endfunction

endpackage

// File: rtl/j11sram.sv
// Async 16-bit SRAM controller behind the J11 dmem port; all SRAM pins registered.
// Latency: read ack at T+RD_WAIT+2, write ack at T+WR_WAIT+4 (T = acceptance cycle).
// Backpressure: one transaction in flight; dmemreq is held until the dmemack pulse. Optional byte parity: J11SRAM_PARITY_EN.
module j11sram
  import j11sram_pkg::*;
#(
  parameter int ADDR_W  = 21,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmemreq,
  input  logic              dmemwr,
  input  logic [21:0]       dmemaddr,
  input  logic [15:0]       dmemwdata,
  output logic              dmemack,
  output logic [15:0]       dmemrdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
`ifdef J11SRAM_PARITY_EN
  ,
  output logic [1:0]        sram_par_o,
  input  logic [1:0]        sram_par_i,
  output logic              perr
`endif
);

  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_WAIT);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, capture;
  logic             ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt, ack_nxt;

  // byte-lane bit 0 and any address bits above the SRAM width are don't-care
  logic unused_addr;
  assign unused_addr = ^dmemaddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      dmemack    <= 1'b0;
      dmemrdata  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
`ifdef J11SRAM_PARITY_EN
      sram_par_o <= '0;
      perr       <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sram_ce_n  <= ce_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      sram_dq_oe <= dq_oe_nxt;
      dmemack    <= ack_nxt;
      if (accept) begin
        sram_addr <= dmemaddr[ADDR_W:1];
        sram_dq_o <= dmemwdata;
`ifdef J11SRAM_PARITY_EN
        sram_par_o <= byte_par(dmemwdata);
`endif
      end
      if (capture) begin
        dmemrdata <= sram_dq_i;
      end
`ifdef J11SRAM_PARITY_EN
      perr <= capture && (sram_par_i != byte_par(sram_dq_i));
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (dmemreq) begin
          state_nxt = dmemwr ? ST_WSETUP : ST_RD;
          cnt_nxt   = dmemwr ? '0 : RD_CNT;
        end
      end
      ST_RD: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = ST_ACK;
      end
      ST_WSETUP: begin
        state_nxt = ST_WPULSE;
        cnt_nxt   = WR_CNT;
      end
      ST_WPULSE: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = ST_WHOLD;
      end
      ST_WHOLD: state_nxt = ST_ACK;
      // ACK ignores dmemreq so a still-held request is not issued twice
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pins are registered, so each control is decoded from the state being entered.
  always_comb begin
    accept    = (state == ST_IDLE) && dmemreq;
    capture   = (state == ST_RD) && (cnt == '0);
    ce_n_nxt  = !(state_nxt inside {ST_RD, ST_WSETUP, ST_WPULSE, ST_WHOLD});
    oe_n_nxt  = (state_nxt != ST_RD);
    we_n_nxt  = (state_nxt != ST_WPULSE);
    dq_oe_nxt = (state_nxt inside {ST_WSETUP, ST_WPULSE, ST_WHOLD});
    ack_nxt   = (state_nxt == ST_ACK);
  end

endmodule

// File: tb/tb_j11sram.sv
// Scoreboard bench for j11sram: directed transactions against a behavioural async SRAM.
module tb_j11sram;

  localparam int ADDR_W  = 21;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              dmemreq, dmemwr;
  logic [21:0]       dmemaddr;
  logic [15:0]       dmemwdata;
  logic              dmemack;
  logic [15:0]       dmemrdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o, sram_dq_i;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef J11SRAM_PARITY_EN
  logic [1:0]        sram_par_o, sram_par_i;
  logic              perr;
`endif
  logic              par_flip = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic        wr;
    logic [15:0] rdata;
    logic [20:0] addr;
    int          ack_cyc;
    int          rd_cyc;
    int          we_cyc;
    int          oe_cyc;
    logic        perr;
  } exp_t;

  exp_t sb[$];

  j11sram #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .dmemreq(dmemreq), .dmemwr(dmemwr), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
    .dmemack(dmemack), .dmemrdata(dmemrdata),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
`ifdef J11SRAM_PARITY_EN
    , .sram_par_o(sram_par_o), .sram_par_i(sram_par_i), .perr(perr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: word array plus stored parity bits.
  logic [15:0] mem     [0:(1<<ADDR_W)-1];
  logic [1:0]  par_mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (rst) begin
      mem[21'h000100]     <= 16'h1234;
      par_mem[21'h000100] <= 2'b01;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem[sram_addr] <= sram_dq_o;
`ifdef J11SRAM_PARITY_EN
      par_mem[sram_addr] <= sram_par_o;
`endif
    end
  end

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;
`ifdef J11SRAM_PARITY_EN
  assign sram_par_i = par_mem[sram_addr] ^ {par_flip, 1'b0};
`endif

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  // Monitor: counts pin activity per transaction and checks each ack against the queue.
  int rd_cnt = 0, we_cnt = 0, oe_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0; we_cnt = 0; oe_cnt = 0;
    end else begin
      if (!sram_oe_n && sram_dq_oe) begin
        nerr++;
        $display("FAIL bus_contention at cycle %0d: oe_n=0 with dq_oe=1", cyc);
      end
      if (!sram_ce_n && !sram_oe_n) rd_cnt++;
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) oe_cnt++;
`ifdef J11SRAM_PARITY_EN
      if (perr && !dmemack) begin
        nerr++;
        $display("FAIL perr_outside_ack at cycle %0d: got 1 expected 0", cyc);
      end
`endif
      if (dmemack) begin
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_ack at cycle %0d: got ack expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_cycle", cyc, e.ack_cyc);
          if (!e.wr) chk("rdata", dmemrdata, e.rdata);
          chk("sram_addr", sram_addr, e.addr);
          chk("read_ctl_cycles", rd_cnt, e.rd_cyc);
          chk("we_low_cycles", we_cnt, e.we_cyc);
          chk("dq_oe_cycles", oe_cnt, e.oe_cyc);
          chk("ack_ctl_idle", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
`ifdef J11SRAM_PARITY_EN
          chk("perr", perr, e.perr);
`endif
        end
        rd_cnt = 0; we_cnt = 0; oe_cnt = 0;
      end
    end
  end

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dmemack && n < 60);
    if (!dmemack) begin
      nerr++;
      $display("FAIL ack_timeout at cycle %0d: got no ack expected ack", cyc);
    end
  endtask

  // Drive a request in cycle t_issue (caller is at the negedge of that cycle) and wait for its ack.
  task automatic txn(input logic wr, input logic [21:0] addr, input logic [15:0] wd,
                     input logic [15:0] exp_rd, input logic exp_perr, input int t_issue);
    exp_t e;
    dmemreq   = 1'b1;
    dmemwr    = wr;
    dmemaddr  = addr;
    dmemwdata = wd;
    e.wr      = wr;
    e.rdata   = exp_rd;
    e.addr    = addr[21:1];
    e.ack_cyc = t_issue + (wr ? WR_WAIT + 4 : RD_WAIT + 2);
    e.rd_cyc  = wr ? 0 : RD_WAIT + 1;
    e.we_cyc  = wr ? WR_WAIT + 1 : 0;
    e.oe_cyc  = wr ? WR_WAIT + 3 : 0;
    e.perr    = exp_perr;
    sb.push_back(e);
    wait_ack();
  endtask

  task automatic drop();
    dmemreq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dmemreq = 1'b0; dmemwr = 1'b0; dmemaddr = '0; dmemwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", dmemack, 1'b0);
    chk("rst_rdata", dmemrdata, 16'h0);
    chk("rst_addr", sram_addr, 21'h0);
    chk("rst_dq_o", sram_dq_o, 16'h0);
    chk("rst_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
`ifdef J11SRAM_PARITY_EN
    chk("rst_perr", perr, 1'b0);
    chk("rst_par_o", sram_par_o, 2'b00);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Read preloaded word 0x100 via byte address 0x200
    txn(1'b0, 22'h000200, 16'h0, 16'h1234, 1'b0, cyc);
    drop();
    chk("rdata_hold", dmemrdata, 16'h1234);

    // Write 0xBEEF to word 0x102
    txn(1'b1, 22'h000204, 16'hBEEF, 16'h0, 1'b0, cyc);
    drop();
    chk("mem_0x102", mem[21'h000102], 16'hBEEF);

    // Back-to-back with request held: second accepted the cycle after ACK
    txn(1'b1, 22'h000300, 16'hA5A5, 16'h0, 1'b0, cyc);
    txn(1'b0, 22'h000300, 16'h0, 16'hA5A5, 1'b0, cyc + 1);
    drop();
    chk("rdata_hold_b2b", dmemrdata, 16'hA5A5);

    // Byte-address bit 0 ignored; top of the word space
    txn(1'b0, 22'h000205, 16'h0, 16'hBEEF, 1'b0, cyc);
    drop();
    txn(1'b1, 22'h3FFFFF, 16'h5A5A, 16'h0, 1'b0, cyc);
    drop();
    txn(1'b0, 22'h3FFFFE, 16'h0, 16'h5A5A, 1'b0, cyc);
    drop();

    // Reset during the write pulse: no ack, controls released next cycle
    dmemreq = 1'b1; dmemwr = 1'b1; dmemaddr = 22'h000400; dmemwdata = 16'h7777;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (sram_we_n && n < 20);
      chk("reached_wpulse", sram_we_n, 1'b0);
    end
    rst = 1'b1;
    dmemreq = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    chk("rst_mid_ack", dmemack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(1'b0, 22'h000200, 16'h0, 16'h1234, 1'b0, cyc);
    drop();

`ifdef J11SRAM_PARITY_EN
    // 0x0103: low byte 0x03 has two ones -> par[0]=0; high byte 0x01 -> par[1]=1
    txn(1'b1, 22'h000500, 16'h0103, 16'h0, 1'b0, cyc);
    chk("par_o", sram_par_o, 2'b10);
    drop();
    par_flip = 1'b1;
    txn(1'b0, 22'h000500, 16'h0, 16'h0103, 1'b1, cyc);
    drop();
    chk("perr_one_cycle", perr, 1'b0);
    par_flip = 1'b0;
    txn(1'b0, 22'h000500, 16'h0, 16'h0103, 1'b0, cyc);
    drop();
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
